sdram_pattern_tester: RTL and testbench

//  Built-in self-test sequencer that sits directly upstream of the SDRAM controller on its sys_ interface.
//  On start it runs two phases over [ADDR_FIRST..ADDR_LAST]:
//   - write phase: one single-word write per address;
//   - read phase: reads every address back and compares it against the regenerated expected word.

---
 rtl/sdram_pattern_tester.sv | 241 ++++++++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_tester.sv
// Built-in self-test sequencer on the SDRAM controller sys_ interface: write a pattern, read it back, report mismatches.
// Build option SDRAM_TESTER_LFSR_EN selects a 16-bit LFSR data pattern instead of the address-derived one.
module sdram_pattern_tester #(
    parameter int                ADDR_W     = 22,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] ADDR_FIRST = '0,
    parameter logic [ADDR_W-1:0] ADDR_LAST  = '1,
    parameter int                TIMEOUT    = 1023
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout_err,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [ADDR_W-1:0] sys_addr,
    output logic [DATA_W-1:0] sys_data_to_sdram,
    output logic              sys_write_rq,
    output logic              sys_read_rq,
    input  logic              sys_write_done,
    input  logic [DATA_W-1:0] sys_data_from_sdram,
    input  logic              sys_data_from_sdram_valid,
    output logic [2:0]        fsm_state
);

    // Handshake: a request is a registered level raised on entering *_REQ and held until its
    // 1-cycle ack; an ack only counts in the *_REQ state whose request it answers.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_GAP = 3'd2,
        RD_REQ = 3'd3,
        RD_GAP = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [10:0] WAIT_LIMIT = 11'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [10:0]       wait_cnt, wait_nxt;
    logic              gap_cnt, gap_nxt;
    logic              write_rq_nxt, read_rq_nxt;
    logic              busy_nxt, done_nxt, pass_nxt, timeout_nxt;
    logic [15:0]       err_count_nxt;
    logic [ADDR_W-1:0] first_addr_nxt;
    logic [DATA_W-1:0] first_data_nxt;
    logic [DATA_W-1:0] pattern;

`ifdef SDRAM_TESTER_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr, lfsr_nxt;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    assign pattern = lfsr;
`else
    assign pattern = addr[15:0] ^ {10'b0, addr[21:16]};
`endif

    assign sys_addr          = addr;
    assign sys_data_to_sdram = pattern;
    assign fsm_state         = state;

    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        wait_nxt       = wait_cnt;
        gap_nxt        = gap_cnt;
        write_rq_nxt   = sys_write_rq;
        read_rq_nxt    = sys_read_rq;
        busy_nxt       = busy;
        done_nxt       = done;
        pass_nxt       = pass;
        timeout_nxt    = timeout_err;
        err_count_nxt  = err_count;
        first_addr_nxt = first_err_addr;
        first_data_nxt = first_err_data;
`ifdef SDRAM_TESTER_LFSR_EN
        lfsr_nxt       = lfsr;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    err_count_nxt  = '0;
                    first_addr_nxt = '0;
                    first_data_nxt = '0;
                    timeout_nxt    = 1'b0;
                    done_nxt       = 1'b0;
                    pass_nxt       = 1'b0;
                    busy_nxt       = 1'b1;
                    addr_nxt       = ADDR_FIRST;
                    wait_nxt       = '0;
                    write_rq_nxt   = 1'b1;
                    state_nxt      = WR_REQ;
`ifdef SDRAM_TESTER_LFSR_EN
                    lfsr_nxt       = LFSR_SEED;
`endif
                end
            end

            WR_REQ: begin
                if (sys_write_done) begin
                    write_rq_nxt = 1'b0;
                    gap_nxt      = 1'b0;
                    state_nxt    = WR_GAP;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    write_rq_nxt = 1'b0;
                    timeout_nxt  = 1'b1;
                    state_nxt    = FINISH;
                end else begin
                    wait_nxt = wait_cnt + 11'd1;
                end
            end

            // Two idle cycles let the controller settle back to its own IDLE.
            WR_GAP: begin
                if (!gap_cnt) begin
                    gap_nxt = 1'b1;
                end else if (addr == ADDR_LAST) begin
                    addr_nxt    = ADDR_FIRST;
                    wait_nxt    = '0;
                    read_rq_nxt = 1'b1;
                    state_nxt   = RD_REQ;
`ifdef SDRAM_TESTER_LFSR_EN
                    lfsr_nxt    = LFSR_SEED;
`endif
                end else begin
                    addr_nxt     = addr + ADDR_W'(1);
                    wait_nxt     = '0;
                    write_rq_nxt = 1'b1;
                    state_nxt    = WR_REQ;
`ifdef SDRAM_TESTER_LFSR_EN
                    lfsr_nxt     = lfsr_step(lfsr);
`endif
                end
            end

            RD_REQ: begin
                if (sys_data_from_sdram_valid) begin
                    read_rq_nxt = 1'b0;
                    gap_nxt     = 1'b0;
                    state_nxt   = RD_GAP;
                    if (sys_data_from_sdram != pattern) begin
                        if (err_count != 16'hFFFF) begin
                            err_count_nxt = err_count + 16'd1;
                        end
                        // err_count never returns to zero, so zero marks the first mismatch.
                        if (err_count == 16'd0) begin
                            first_addr_nxt = addr;
                            first_data_nxt = sys_data_from_sdram;
                        end
                    end
                end else if (wait_cnt == WAIT_LIMIT) begin
                    read_rq_nxt = 1'b0;
                    timeout_nxt = 1'b1;
                    state_nxt   = FINISH;
                end else begin
                    wait_nxt = wait_cnt + 11'd1;
                end
            end

            RD_GAP: begin
                if (!gap_cnt) begin
                    gap_nxt = 1'b1;
                end else if (addr == ADDR_LAST) begin
                    state_nxt = FINISH;
                end else begin
                    addr_nxt    = addr + ADDR_W'(1);
                    wait_nxt    = '0;
                    read_rq_nxt = 1'b1;
                    state_nxt   = RD_REQ;
`ifdef SDRAM_TESTER_LFSR_EN
                    lfsr_nxt    = lfsr_step(lfsr);
`endif
                end
            end

            FINISH: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                pass_nxt  = (err_count == 16'd0) && !timeout_err;
                state_nxt = IDLE;
            end

            default: begin
                write_rq_nxt = 1'b0;
                read_rq_nxt  = 1'b0;
                state_nxt    = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            addr           <= ADDR_FIRST;
            wait_cnt       <= '0;
            gap_cnt        <= 1'b0;
            sys_write_rq   <= 1'b0;
            sys_read_rq    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout_err    <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
`ifdef SDRAM_TESTER_LFSR_EN
            lfsr           <= '0;
`endif
        end else begin
            state          <= state_nxt;
            addr           <= addr_nxt;
            wait_cnt       <= wait_nxt;
            gap_cnt        <= gap_nxt;
            sys_write_rq   <= write_rq_nxt;
            sys_read_rq    <= read_rq_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            timeout_err    <= timeout_nxt;
            err_count      <= err_count_nxt;
            first_err_addr <= first_addr_nxt;
            first_err_data <= first_data_nxt;
`ifdef SDRAM_TESTER_LFSR_EN
            lfsr           <= lfsr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester over a 16-word behavioural controller model (ack 3 cycles after rq).
// Covers clean run, single corrupted read, write-ack timeout, mid-run reset and start handling.
module tb_sdram_pattern_tester;

    localparam int ADDR_W  = 22;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 31;
    localparam int N_WORDS = 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout_err;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_data;
    logic [ADDR_W-1:0] sys_addr;
    logic [DATA_W-1:0] sys_data_to_sdram;
    logic              sys_write_rq;
    logic              sys_read_rq;
    logic              sys_write_done;
    logic [DATA_W-1:0] sys_data_from_sdram;
    logic              sys_data_from_sdram_valid;
    logic [2:0]        fsm_state;

    logic no_write_ack;
    logic flip_bit;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wa_q[$];
    logic [DATA_W-1:0] wd_q[$];
    logic [ADDR_W-1:0] ra_q[$];
    logic [DATA_W-1:0] exp_q[$];

    sdram_pattern_tester #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ADDR_FIRST(22'd0),
        .ADDR_LAST (22'd15),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .sys_clk                  (sys_clk),
        .sys_rst_n                (sys_rst_n),
        .start                    (start),
        .busy                     (busy),
        .done                     (done),
        .pass                     (pass),
        .timeout_err              (timeout_err),
        .err_count                (err_count),
        .first_err_addr           (first_err_addr),
        .first_err_data           (first_err_data),
        .sys_addr                 (sys_addr),
        .sys_data_to_sdram        (sys_data_to_sdram),
        .sys_write_rq             (sys_write_rq),
        .sys_read_rq              (sys_read_rq),
        .sys_write_done           (sys_write_done),
        .sys_data_from_sdram      (sys_data_from_sdram),
        .sys_data_from_sdram_valid(sys_data_from_sdram_valid),
        .fsm_state                (fsm_state)
    );

    // Clock/reset
    always #5 sys_clk = ~sys_clk;

    // Controller model: acks on the third edge that sees a request, once per request.
    logic [1:0]        ack_cnt;
    logic              served;
    logic [DATA_W-1:0] mem [N_WORDS];

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ack_cnt                   <= 2'd0;
            served                    <= 1'b0;
            sys_write_done            <= 1'b0;
            sys_data_from_sdram_valid <= 1'b0;
            sys_data_from_sdram       <= '0;
        end else begin
            sys_write_done            <= 1'b0;
            sys_data_from_sdram_valid <= 1'b0;
            if (!sys_write_rq && !sys_read_rq) begin
                ack_cnt <= 2'd0;
                served  <= 1'b0;
            end else if (!served) begin
                if (ack_cnt != 2'd2) begin
                    ack_cnt <= ack_cnt + 2'd1;
                end else if (sys_write_rq) begin
                    if (!no_write_ack) begin
                        sys_write_done         <= 1'b1;
                        served                 <= 1'b1;
                        mem[sys_addr[3:0]]     <= sys_data_to_sdram;
                        wa_q.push_back(sys_addr);
                        wd_q.push_back(sys_data_to_sdram);
                    end
                end else begin
                    sys_data_from_sdram_valid <= 1'b1;
                    served                    <= 1'b1;
                    sys_data_from_sdram       <= mem[sys_addr[3:0]] ^
                        ((flip_bit && sys_addr == 22'd5) ? 16'h0008 : 16'h0000);
                    ra_q.push_back(sys_addr);
                end
            end
        end
    end

    // Reference pattern for the word at index idx of a run.
    function automatic logic [DATA_W-1:0] exp_word(input int idx);
`ifdef SDRAM_TESTER_LFSR_EN
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < idx; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        return l;
`else
        logic [21:0] a;
        a = 22'(idx);
        return a[15:0] ^ {10'b0, a[21:16]};
`endif
    endfunction

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_write_addr(input logic [ADDR_W-1:0] a, input int budget);
        int n;
        n = 0;
        while (!(sys_write_rq && sys_addr == a) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check("wait_wr_addr", 32'(sys_write_rq && sys_addr == a), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy),              32'd0);
        check({tag, "_done"},  32'(done),              32'd0);
        check({tag, "_pass"},  32'(pass),              32'd0);
        check({tag, "_tmo"},   32'(timeout_err),       32'd0);
        check({tag, "_errc"},  32'(err_count),         32'd0);
        check({tag, "_fea"},   32'(first_err_addr),    32'd0);
        check({tag, "_fed"},   32'(first_err_data),    32'd0);
        check({tag, "_addr"},  32'(sys_addr),          32'd0);
        check({tag, "_wdata"}, 32'(sys_data_to_sdram), 32'd0);
        check({tag, "_wrq"},   32'(sys_write_rq),      32'd0);
        check({tag, "_rrq"},   32'(sys_read_rq),       32'd0);
    endtask

    // Compare the traffic of one complete run against the expected write stream.
    task automatic check_run(input string tag, input int wb, input int rb);
        logic [DATA_W-1:0] e;
        exp_q.delete();
        for (int i = 0; i < N_WORDS; i++) exp_q.push_back(exp_word(i));
        check({tag, "_wr_cnt"}, 32'(wd_q.size() - wb), 32'(N_WORDS));
        check({tag, "_rd_cnt"}, 32'(ra_q.size() - rb), 32'(N_WORDS));
        for (int i = 0; i < N_WORDS; i++) begin
            e = exp_q.pop_front();
            if (wb + i < wd_q.size()) begin
                check({tag, "_wr_addr"}, 32'(wa_q[wb + i]), 32'(i));
                check({tag, "_wr_data"}, 32'(wd_q[wb + i]), 32'(e));
            end
            if (rb + i < ra_q.size()) begin
                check({tag, "_rd_addr"}, 32'(ra_q[rb + i]), 32'(i));
            end
        end
    endtask

    task automatic check_flip_result(input string tag);
        check({tag, "_done"}, 32'(done),           32'd1);
        check({tag, "_pass"}, 32'(pass),           32'd0);
        check({tag, "_errc"}, 32'(err_count),      32'd1);
        check({tag, "_fea"},  32'(first_err_addr), 32'd5);
        check({tag, "_fed"},  32'(first_err_data), 32'(exp_word(5) ^ 16'h0008));
        check({tag, "_busy"}, 32'(busy),           32'd0);
    endtask

    initial begin
        int wb;
        int rb;
        int n;

        sys_rst_n    = 1'b0;
        start        = 1'b0;
        no_write_ack = 1'b0;
        flip_bit     = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_idle_outputs("rst");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Clean run, with a start pulse while busy that must be ignored
        wb = wd_q.size();
        rb = ra_q.size();
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_wrq", 32'(sys_write_rq), 32'd1);
        repeat (20) @(negedge sys_clk);
        pulse_start();
        check("t5_busy_ignored", 32'(busy), 32'd1);
        wait_done("t1_done_wait", 2000);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_errc", 32'(err_count), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_tmo", 32'(timeout_err), 32'd0);
        check("t1_rq_end", 32'({sys_write_rq, sys_read_rq}), 32'd0);
        check_run("t1", wb, rb);

        // One corrupted read at address 5
        flip_bit = 1'b1;
        wb = wd_q.size();
        rb = ra_q.size();
        pulse_start();
        wait_done("t2_done_wait", 2000);
        check_flip_result("t2");
        check_run("t2", wb, rb);

        // Restart after done clears results, then repeats them
        wb = wd_q.size();
        rb = ra_q.size();
        pulse_start();
        check("t5_done_clr", 32'(done), 32'd0);
        check("t5_errc_clr", 32'(err_count), 32'd0);
        check("t5_fea_clr", 32'(first_err_addr), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        wait_done("t5_done_wait", 2000);
        check_flip_result("t5");
        check_run("t5", wb, rb);
        flip_bit = 1'b0;

        // Write ack never arrives
        no_write_ack = 1'b1;
        pulse_start();
        check("t3_wrq_up", 32'(sys_write_rq), 32'd1);
        check("t3_addr0", 32'(sys_addr), 32'd0);
        n = 0;
        while (!timeout_err && n < 100) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check("t3_tmo_cycles", 32'(n), 32'(TIMEOUT));
        check("t3_tmo", 32'(timeout_err), 32'd1);
        check("t3_wrq_down", 32'(sys_write_rq), 32'd0);
        wait_done("t3_done_wait", 50);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        no_write_ack = 1'b0;
        @(negedge sys_clk);

        // Reset in the middle of the write to address 7
        pulse_start();
        wait_write_addr(22'd7, 500);
        sys_rst_n = 1'b0;
        #1;
        check_idle_outputs("t4_rst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        wb = wd_q.size();
        rb = ra_q.size();
        pulse_start();
        check("t4_restart_addr", 32'(sys_addr), 32'd0);
        check("t4_restart_wrq", 32'(sys_write_rq), 32'd1);
        wait_done("t4_done_wait", 2000);
        check("t4_pass", 32'(pass), 32'd1);
        check("t4_errc", 32'(err_count), 32'd0);
        check_run("t4", wb, rb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
